// File: rtl/mseq_multi_gen.sv
// mseq_multi_gen: bank of CH_NUM Fibonacci LFSRs seeded from a FIFO of wide chaotic words.
// Build macro MSEQ_SEED_OFFSET_EN: add the channel index to each seed slice before the zero guard.

module mseq_lfsr_lane #(
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] POLY       = 16'hD008
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  output logic                  msb_o
);
  logic [LFSR_WIDTH-1:0] state_q, state_d;
  logic                  fb;

  always_comb begin
    fb      = ^(state_q & POLY);
    state_d = state_q;
    if (load_i)      state_d = seed_i;
    else if (step_i) state_d = {state_q[LFSR_WIDTH-2:0], fb};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= '0;
    else       state_q <= state_d;
  end

  assign msb_o = state_q[LFSR_WIDTH-1];
endmodule

module mseq_multi_gen #(
  parameter int                    IN_WIDTH      = 288,
  parameter int                    CH_NUM        = 16,
  parameter int                    LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0] POLY          = 16'hD008,
  parameter int                    FIFO_DEPTH    = 4,
  parameter int                    WARMUP_CYCLES = 512,
  parameter int                    RESEED_PERIOD = 1024
) (
  input  logic                          MSEQ_clk,
  input  logic                          MSEQ_rst,
  input  logic [IN_WIDTH-1:0]           MSEQ_din,
  input  logic                          MSEQ_din_vld,
  output logic                          MSEQ_din_rdy,
  output logic [CH_NUM-1:0]             MSEQ_output,
  output logic                          MSEQ_output_vld,
  output logic                          MSEQ_seed_starve,
  output logic [$clog2(FIFO_DEPTH):0]   MSEQ_fifo_level
);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = PTR_W + 1;
  localparam int SEED_BITS = CH_NUM * LFSR_WIDTH;
  localparam int WU_W      = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int RP_W      = (RESEED_PERIOD > 1) ? $clog2(RESEED_PERIOD) : 1;
  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_CYCLES - 1);
  localparam logic [RP_W-1:0]  RP_LAST  = RP_W'((RESEED_PERIOD > 0) ? RESEED_PERIOD - 1 : 0);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {WARMUP, WAIT_SEED, RUN} state_e;

  // ---------------- seed FIFO ----------------
  logic [IN_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q;
  logic                push, pop, fifo_empty;
  logic [IN_WIDTH-1:0] pop_word;

  assign MSEQ_din_rdy = (level_q != LVL_FULL);
  assign fifo_empty   = (level_q == '0);
  assign push         = MSEQ_din_vld & MSEQ_din_rdy;
  assign pop_word     = mem_q[rd_ptr_q];

  always_ff @(posedge MSEQ_clk) begin
    if (MSEQ_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is not reset; the pointers and level flush it.
  always_ff @(posedge MSEQ_clk) begin
    if (push) mem_q[wr_ptr_q] <= MSEQ_din;
  end

  // ---------------- control FSM ----------------
  state_e          state_q, state_d;
  logic [WU_W-1:0] wu_cnt_q, wu_cnt_d;
  logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
  logic            pend_q, pend_d;
  logic            load, step, term, starve;

  always_comb begin
    state_d  = state_q;
    wu_cnt_d = wu_cnt_q;
    rp_cnt_d = rp_cnt_q;
    pend_d   = pend_q;
    pop      = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    starve   = 1'b0;
    term     = (RESEED_PERIOD != 0) && (rp_cnt_q == RP_LAST);
    unique case (state_q)
      WARMUP: begin
        if (wu_cnt_q == WU_LAST) state_d  = WAIT_SEED;
        else                     wu_cnt_d = wu_cnt_q + WU_W'(1);
      end
      WAIT_SEED: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          load     = 1'b1;
          rp_cnt_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (term && !fifo_empty) begin
          pop      = 1'b1;
          load     = 1'b1;
          rp_cnt_d = '0;
          pend_d   = 1'b0;
        end else begin
          step = 1'b1;
          // Overdue reseed: hold at terminal count, flag starvation only once.
          if (term) begin
            starve = ~pend_q;
            pend_d = 1'b1;
          end else begin
            rp_cnt_d = rp_cnt_q + RP_W'(1);
          end
        end
      end
      default: state_d = WARMUP;
    endcase
  end

  always_ff @(posedge MSEQ_clk) begin
    if (MSEQ_rst) begin
      state_q  <= WARMUP;
      wu_cnt_q <= '0;
      rp_cnt_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wu_cnt_q <= wu_cnt_d;
      rp_cnt_q <= rp_cnt_d;
      pend_q   <= pend_d;
    end
  end

  assign MSEQ_output_vld  = (state_q == RUN);
  assign MSEQ_seed_starve = starve;
  assign MSEQ_fifo_level  = level_q;

  // ---------------- per-channel lanes ----------------
  logic [CH_NUM-1:0][LFSR_WIDTH-1:0] seeds;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_lane
    logic [LFSR_WIDTH-1:0] slice, biased;
    assign slice = pop_word[g*LFSR_WIDTH +: LFSR_WIDTH];
`ifdef MSEQ_SEED_OFFSET_EN
    assign biased = slice + LFSR_WIDTH'(g);
`else
    assign biased = slice;
`endif
    assign seeds[g] = (biased == '0) ? LFSR_WIDTH'(1) : biased;

    mseq_lfsr_lane #(
      .LFSR_WIDTH (LFSR_WIDTH),
      .POLY       (POLY)
    ) u_lane (
      .clk_i  (MSEQ_clk),
      .rst_i  (MSEQ_rst),
      .load_i (load),
      .step_i (step),
      .seed_i (seeds[g]),
      .msb_o  (MSEQ_output[g])
    );
  end

  if (IN_WIDTH > SEED_BITS) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^pop_word[IN_WIDTH-1:SEED_BITS];
  end
endmodule

// File: tb/tb_mseq_multi_gen.sv
// Bench for mseq_multi_gen: random word stream into a cycle-level reference model,
// expected status/outputs queued and compared by an independent negedge monitor.
module tb_mseq_multi_gen;
  localparam int CH = 4, W = 4, IN_W = 20, DEPTH = 4, WU = 8, P = 5, PERIOD = 15;
  localparam logic [W-1:0] POLY = 4'h9;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  din;
  logic             din_vld, din_rdy;
  logic [CH-1:0]    dout;
  logic             dout_vld, starve;
  logic [LVL_W-1:0] level;

  always #5 clk = ~clk;

  mseq_multi_gen #(
    .IN_WIDTH (IN_W), .CH_NUM (CH), .LFSR_WIDTH (W), .POLY (POLY),
    .FIFO_DEPTH (DEPTH), .WARMUP_CYCLES (WU), .RESEED_PERIOD (P)
  ) dut (
    .MSEQ_clk         (clk),
    .MSEQ_rst         (rst),
    .MSEQ_din         (din),
    .MSEQ_din_vld     (din_vld),
    .MSEQ_din_rdy     (din_rdy),
    .MSEQ_output      (dout),
    .MSEQ_output_vld  (dout_vld),
    .MSEQ_seed_starve (starve),
    .MSEQ_fifo_level  (level)
  );

  typedef struct { bit vld; int level; bit rdy; bit starve; } stat_t;
  stat_t         stat_q[$];
  logic [CH-1:0] exp_q[$];
  int            checks = 0, errors = 0;
  bit            mon_en = 1'b0;
  int            pcts[6] = '{100, 0, 30, 70, 10, 100};

  // Reference model: m-sequence as a ring of states, channels tracked by ring position.
  logic [W-1:0]    ring[PERIOD];
  int              posof[16];
  logic [IN_W-1:0] m_wq[$];
  int              m_mode, m_edges, m_runlen;
  int              m_pos[CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] model_out();
    logic [CH-1:0] o;
    for (int c = 0; c < CH; c++) o[c] = ring[m_pos[c]][W-1];
    return o;
  endfunction

  function automatic void model_load(input logic [IN_W-1:0] w);
    for (int c = 0; c < CH; c++) begin
      int s;
      s = int'(w[c*W +: W]);
`ifdef MSEQ_SEED_OFFSET_EN
      s = (s + c) % (1 << W);
`endif
      if (s == 0) s = 1;
      m_pos[c] = posof[s];
    end
  endfunction

  function automatic void model_edge(input bit r, input bit v, input logic [IN_W-1:0] d);
    bit have, push;
    if (r) begin
      m_wq.delete();
      m_mode = 0; m_edges = 0; m_runlen = 0;
      return;
    end
    have = m_wq.size() > 0;
    push = v && (m_wq.size() < DEPTH);
    case (m_mode)
      0: begin
        m_edges++;
        if (m_edges >= WU) m_mode = 1;
      end
      1: if (have) begin
        model_load(m_wq.pop_front());
        m_mode = 2; m_runlen = 0;
      end
      default: begin
        if (m_runlen + 1 >= P && have) begin
          model_load(m_wq.pop_front());
          m_runlen = 0;
        end else begin
          for (int c = 0; c < CH; c++) m_pos[c] = (m_pos[c] + 1) % PERIOD;
          m_runlen++;
        end
      end
    endcase
    if (push) m_wq.push_back(d);
  endfunction

  // One clock cycle: drive inputs, queue what the DUT must show this cycle, advance the model.
  task automatic tick(input bit r, input bit v, input logic [IN_W-1:0] d);
    stat_t st;
    rst = r; din_vld = v; din = d;
    st.vld    = (m_mode == 2);
    st.level  = m_wq.size();
    st.rdy    = m_wq.size() < DEPTH;
    st.starve = (m_mode == 2) && (m_runlen + 1 == P) && (m_wq.size() == 0);
    stat_q.push_back(st);
    if (m_mode == 2) exp_q.push_back(model_out());
    model_edge(r, v, d);
    @(posedge clk); #1;
  endtask

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] w;
    w = IN_W'($urandom);
    for (int c = 0; c < CH; c++) if ($urandom_range(0, 3) == 0) w[c*W +: W] = '0;
    return w;
  endfunction

  always @(negedge clk) begin : monitor
    stat_t         st;
    logic [CH-1:0] e;
    if (mon_en) begin
      if (stat_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL stat_queue: nothing expected at %0t", $time);
      end else begin
        st = stat_q.pop_front();
        chk("output_vld",  32'(dout_vld), 32'(st.vld));
        chk("fifo_level",  32'(level),    st.level);
        chk("din_rdy",     32'(din_rdy),  32'(st.rdy));
        chk("seed_starve", 32'(starve),   32'(st.starve));
        if (!st.vld) chk("output_idle", 32'(dout), 0);
      end
      if (dout_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL output_unexpected: got %0h with no expected word at %0t", dout, $time);
        end else begin
          e = exp_q.pop_front();
          chk("output", 32'(dout), 32'(e));
        end
      end
    end
  end

  initial begin : stim
    logic [W-1:0]    s;
    logic [IN_W-1:0] w;
    int              n;
    for (int i = 0; i < 16; i++) posof[i] = 0;
    s = 1;
    for (int i = 0; i < PERIOD; i++) begin
      ring[i] = s;
      posof[s] = i;
      s = {s[W-2:0], ^(s & POLY)};
    end

    rst = 1'b1; din_vld = 1'b0; din = '0;
    @(posedge clk); #1;
    model_edge(1'b1, 1'b0, '0);
    mon_en = 1'b1;
    repeat (2) tick(1'b1, 1'b0, '0);

    // All-zero seed slices (junk in ignored top bits), pushed in the first cycle after release.
    w = 20'hA0000;
    tick(1'b0, 1'b1, w);
    // Reseed falls due with an empty FIFO.
    repeat (25) tick(1'b0, 1'b0, '0);
    // Identical slices of 3; late push triggers the pending reseed.
    w = 20'h53333;
    tick(1'b0, 1'b1, w);
    repeat (8) tick(1'b0, 1'b0, '0);

    for (int k = 0; k < 6; k++)
      repeat (40) tick(1'b0, $urandom_range(0, 99) < pcts[k], rand_word());

    // Bring the FIFO to three words, then a single reset cycle.
    n = 0;
    while (m_wq.size() != 3 && n < 60) begin
      tick(1'b0, m_wq.size() < 3, rand_word());
      n++;
    end
    tick(1'b1, 1'b0, '0);
    // Continuous pushes through warmup: FIFO fills and holds at depth.
    repeat (30) tick(1'b0, 1'b1, rand_word());
    repeat (60) tick(1'b0, $urandom_range(0, 1) == 1, rand_word());

    mon_en = 1'b0;
    chk("stat_drain", stat_q.size(), 0);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
